fifo_uart_tx: RTL and testbench

Serial transmit stage that drains bytes from the width-converting FIFO's 8-bit read side and sends each one as an 8N1 UART frame on a single output line. It sits directly downstream of the FIFO:
- it watches `empty`;
- it pops one byte with a single-cycle `rd` pulse;
- it serialises that byte LSB first using 16x-oversampled baud ticks.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/fifo_uart_tx_baud_gen.sv | 32 +++
 rtl/fifo_uart_tx.sv | 134 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame/baud constants
// and a counter-width helper, common to the transmitter and a future receiver.
package uart_pkg;

    localparam int UART_DBIT       = 8;
    localparam int UART_SB_TICK    = 16;
    localparam int UART_DVSR       = 326;  // 50 MHz / (16 * 9600)
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// Mod-DVSR counter producing a one-cycle oversampling tick; held at zero
// while clr is high so the first tick lands DVSR cycles after release.
module baud_gen
    import uart_pkg::*;
#(
    parameter int DVSR = UART_DVSR
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = cnt_width(DVSR);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DVSR - 1)) && !clr;

    // NOTE: sequential state is always assigned with <= so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter draining a FIFO read port: pops one byte per frame
// with a single-cycle rd pulse and shifts it out LSB first.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = UART_DBIT,
    parameter int SB_TICK = UART_SB_TICK,
    parameter int DVSR    = UART_DVSR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_en,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_r_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int S_W = cnt_width((SB_TICK > UART_OVERSAMPLE) ? SB_TICK : UART_OVERSAMPLE);
    localparam int N_W = cnt_width(DBIT);

    tx_state_t       state, state_next;
    logic [S_W-1:0]  s, s_next;
    logic [N_W-1:0]  n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic            tx_reg, tx_next;
    logic            done_reg, done_next;
    logic            tick;
    logic            baud_clr;

    assign baud_clr = (state == IDLE);

    baud_gen #(
        .DVSR(DVSR)
    ) u_baud_gen (
        .clk  (clk),
        .reset(reset),
        .clr  (baud_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            s        <= '0;
            n        <= '0;
            b        <= '0;
            tx_reg   <= 1'b1;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            s        <= s_next;
            n        <= n_next;
            b        <= b_next;
            tx_reg   <= tx_next;
            done_reg <= done_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        tx_next    = tx_reg;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (fifo_rd) begin
                    b_next     = fifo_r_data;
                    tx_next    = 1'b0;
                    s_next     = '0;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s == S_W'(UART_OVERSAMPLE - 1)) begin
                        s_next     = '0;
                        n_next     = '0;
                        tx_next    = b[0];
                        state_next = DATA;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == S_W'(UART_OVERSAMPLE - 1)) begin
                        s_next = '0;
                        if (n == N_W'(DBIT - 1)) begin
                            tx_next    = 1'b1;
                            state_next = STOP;
                        end else begin
                            b_next  = b >> 1;
                            tx_next = b_next[0];
                            n_next  = n + 1'b1;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s == S_W'(SB_TICK - 1)) begin
                        s_next     = '0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The reset term keeps a byte from being popped (and lost) while held in reset.
    always_comb begin
        fifo_rd = (state == IDLE) && tx_en && !fifo_empty && reset;
        tx_busy = (state != IDLE);
    end

    assign tx           = tx_reg;
    assign tx_done_tick = done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at DVSR=4 (64-cycle bits, 640-cycle frames)
// with a queue-based FIFO model feeding the read port.
module tb_fifo_uart_tx;

    localparam int TB_DVSR   = 4;
    localparam int BIT_CYC   = 16 * TB_DVSR;
    localparam int FRAME_CYC = 10 * BIT_CYC;

    typedef struct {
        logic tx_en;
        logic fifo_empty;
        logic exp_rd;
    } rd_vec_t;

    typedef struct {
        logic [7:0] data;
        logic [9:0] exp_frame;  // line levels in time order, bit 0 = start bit
        int         exp_gap;    // cycles since previous rd, 0 = not checked
    } frame_vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_r_data;
    logic       fifo_rd;
    logic       tx;
    logic       tx_busy;
    logic       tx_done_tick;

    int         checks = 0;
    int         errors = 0;
    int         cyc_cnt = 0;
    int         rd_on_empty = 0;
    int         rd_cycle = 0;
    int         rd_cycle_prev = 0;
    logic [7:0] fifo_q[$];

    rd_vec_t    rd_vecs[4];
    frame_vec_t frames[4];

    fifo_uart_tx #(
        .DBIT   (8),
        .SB_TICK(16),
        .DVSR   (TB_DVSR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_en       (tx_en),
        .fifo_empty  (fifo_empty),
        .fifo_r_data (fifo_r_data),
        .fifo_rd     (fifo_rd),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done_tick(tx_done_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (fifo_rd && fifo_empty) rd_on_empty <= rd_on_empty + 1;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete within cycle budget");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic fifo_refresh();
        fifo_empty  = (fifo_q.size() == 0);
        fifo_r_data = (fifo_q.size() == 0) ? 8'hff : fifo_q[0];
    endtask

    task automatic fifo_pop();
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_refresh();
    endtask

    task automatic wait_rd(input string tag);
        int waited = 0;
        while (fifo_rd !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_rd_seen"}, fifo_rd, 1);
        rd_cycle_prev = rd_cycle;
        rd_cycle      = cyc_cnt;
    endtask

    // Entered in the rd cycle; returns at the negedge where tx_done_tick is due.
    task automatic run_frame(input logic [9:0] exp_frame, input int drop_at, input string tag);
        int   bit_idx;
        int   pos;
        logic early_done = 1'b0;
        logic not_busy   = 1'b0;
        logic rd_mid     = 1'b0;
        @(posedge clk);
        #1 fifo_pop();
        for (int cyc = 0; cyc <= FRAME_CYC; cyc++) begin
            @(negedge clk);
            if (cyc < FRAME_CYC) begin
                bit_idx = cyc / BIT_CYC;
                pos     = cyc % BIT_CYC;
                if (pos == 0 || pos == BIT_CYC - 1)
                    check($sformatf("%s_bit%0d_%s", tag, bit_idx, (pos == 0) ? "first" : "last"),
                          tx, exp_frame[bit_idx]);
                if (tx_done_tick) early_done = 1'b1;
                if (!tx_busy)     not_busy   = 1'b1;
                if (fifo_rd)      rd_mid     = 1'b1;
            end else begin
                check({tag, "_done_tick"}, tx_done_tick, 1);
                check({tag, "_busy_after"}, tx_busy, 0);
                check({tag, "_tx_idle"}, tx, 1);
            end
            if (cyc == drop_at) tx_en = 1'b0;
        end
        check({tag, "_early_done"}, early_done, 0);
        check({tag, "_busy_gap"}, not_busy, 0);
        check({tag, "_rd_mid_frame"}, rd_mid, 0);
    endtask

    initial begin
        logic flag_rd;
        logic flag_tx;
        logic flag_busy;

        rd_vecs = '{
            '{1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0},
            '{1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b1}
        };
        frames = '{
            '{8'h09, 10'h212, 0},
            '{8'haa, 10'h354, 0},
            '{8'hbb, 10'h376, 641},
            '{8'hcc, 10'h398, 641}
        };

        // Reset held with a non-empty FIFO and tx_en high: nothing may move.
        reset       = 1'b0;
        tx_en       = 1'b1;
        fifo_empty  = 1'b0;
        fifo_r_data = 8'h5a;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst%0d_tx", i), tx, 1);
            check($sformatf("rst%0d_rd", i), fifo_rd, 0);
            check($sformatf("rst%0d_busy", i), tx_busy, 0);
            check($sformatf("rst%0d_done", i), tx_done_tick, 0);
        end
        fifo_refresh();
        reset = 1'b1;
        #1 check("post_rst_rd", fifo_rd, 0);

        // Combinational rd decode in IDLE, all settled before the next edge.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tx_en      = rd_vecs[i].tx_en;
            fifo_empty = rd_vecs[i].fifo_empty;
            #1 check($sformatf("rd_vec%0d", i), fifo_rd, rd_vecs[i].exp_rd);
        end
        tx_en = 1'b1;
        fifo_refresh();

        // Single byte, then three queued bytes sent back to back.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) fifo_q.push_back(frames[0].data);
            if (i == 1) for (int j = 1; j < 4; j++) fifo_q.push_back(frames[j].data);
            if (i <= 1) begin
                fifo_refresh();
                #1;
            end
            wait_rd($sformatf("frame%0d", i));
            if (frames[i].exp_gap != 0)
                check($sformatf("frame%0d_gap", i), rd_cycle - rd_cycle_prev, frames[i].exp_gap);
            run_frame(frames[i].exp_frame, -1, $sformatf("frame%0d", i));
        end

        // Empty FIFO held for 2000 cycles.
        flag_rd   = 1'b0;
        flag_tx   = 1'b0;
        flag_busy = 1'b0;
        repeat (2000) begin
            @(negedge clk);
            if (fifo_rd)  flag_rd   = 1'b1;
            if (!tx)      flag_tx   = 1'b1;
            if (tx_busy)  flag_busy = 1'b1;
        end
        check("empty_hold_rd", flag_rd, 0);
        check("empty_hold_tx_low", flag_tx, 0);
        check("empty_hold_busy", flag_busy, 0);

        // Reset at cycle 200 (inside a zero data bit of 8'hf0); 8'h81 follows intact.
        fifo_q.push_back(8'hf0);
        fifo_q.push_back(8'h81);
        fifo_refresh();
        #1 wait_rd("mid_rst");
        @(posedge clk);
        #1 fifo_pop();
        repeat (201) @(negedge clk);
        check("mid_rst_tx_before", tx, 0);
        check("mid_rst_busy_before", tx_busy, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_tx_async", tx, 1);
        check("mid_rst_busy", tx_busy, 0);
        flag_rd = fifo_rd;
        repeat (2) begin
            @(negedge clk);
            if (fifo_rd) flag_rd = 1'b1;
        end
        check("mid_rst_no_rd", flag_rd, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_next_rd", fifo_rd, 1);
        check("mid_rst_queue_len", fifo_q.size(), 1);
        run_frame(10'h302, -1, "post_rst");

        // tx_en dropped at cycle 100 of the first of two queued bytes.
        fifo_q.push_back(8'h55);
        fifo_q.push_back(8'he7);
        fifo_refresh();
        #1 wait_rd("gate0");
        run_frame(10'h2aa, 100, "gate0");
        flag_rd = fifo_rd;
        repeat (20) begin
            @(negedge clk);
            if (fifo_rd) flag_rd = 1'b1;
        end
        check("gate_no_rd", flag_rd, 0);
        tx_en = 1'b1;
        #1 check("gate_restore_rd", fifo_rd, 1);
        run_frame(10'h3ce, -1, "gate1");

        check("fifo_drained", fifo_q.size(), 0);
        check("rd_on_empty", rd_on_empty, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
